// File: rtl/phy_rx_deserializer.sv
// phy_rx_deserializer
// Receive side of the two-lane serial link. Each lane delivers one bit per
// clk_32f edge, MSB first. The block finds byte alignment from the COM idle
// symbol, declares sync after COMS_TO_SYNC aligned COM pairs, then rebuilds
// 32-bit words striped as lane0 = byte3,byte2 and lane1 = byte1,byte0.
module phy_rx_deserializer #(
    parameter logic [7:0]  COM_BYTE     = 8'hBC,
    parameter int unsigned COMS_TO_SYNC = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        Data_in_1bit_0,
    input  logic        Data_in_1bit_1,
    output logic [31:0] Data_out,
    output logic        valid_out,
    output logic        active_out
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        SYNC   = 2'd2
    } state_e;

    localparam logic [3:0] SYNC_CNT = 4'(COMS_TO_SYNC);

    state_e      state_q, state_d;

    // Only the last seven bits of each lane are stored: the eighth bit of the
    // post-shift byte is the live lane input, so every decision on this edge
    // sees the byte exactly as it will sit in the shift register afterwards.
    logic [6:0]  sr0_q, sr1_q;
    logic [7:0]  byte0_d, byte1_d;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic        half_q, half_d;
    logic [7:0]  hold_hi_q, hold_hi_d;   // word bits [31:24] from lane 0
    logic [7:0]  hold_lo_q, hold_lo_d;   // word bits [15:8]  from lane 1
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;

    logic        com0, com1;
    logic        boundary;

    assign byte0_d  = {sr0_q, Data_in_1bit_0};
    assign byte1_d  = {sr1_q, Data_in_1bit_1};
    assign com0     = (byte0_d == COM_BYTE);
    assign com1     = (byte1_d == COM_BYTE);

    // The boundary edge is the one that shifts in bit 0 of a byte.
    assign boundary = (bit_cnt_q == 3'd7);

    // Alignment FSM and word assembly: next-state and datapath decisions.
    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it
        // unassigned; a missing default here would infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        half_d    = half_q;
        hold_hi_d = hold_hi_q;
        hold_lo_d = hold_lo_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        unique case (state_q)
            SEARCH: begin
                // Unaligned: look at every edge. A COM pair defines the byte
                // grid, so this edge becomes a boundary and counting restarts.
                if (com0 && com1) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    state_d   = (SYNC_CNT == 4'd1) ? SYNC : COUNT;
                end
            end

            COUNT: begin
                if (boundary) begin
                    if (com0 && com1) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_q + 4'd1 == SYNC_CNT) begin
                            state_d = SYNC;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = SEARCH;
                    end
                end
            end

            SYNC: begin
                if (boundary) begin
                    if (com0 && com1) begin
                        // Idle pair: a half-built word can never be completed.
                        half_d = 1'b0;
                    end else if (!com0 && !com1) begin
                        if (!half_q) begin
                            hold_hi_d = byte0_d;
                            hold_lo_d = byte1_d;
                            half_d    = 1'b1;
                        end else begin
                            data_d  = {hold_hi_q, byte0_d, hold_lo_q, byte1_d};
                            valid_d = 1'b1;
                            half_d  = 1'b0;
                        end
                    end else begin
                        // Lanes disagree on idle: alignment is lost. This
                        // takes priority over completing a word.
                        half_d    = 1'b0;
                        com_cnt_d = 4'd0;
                        state_d   = SEARCH;
                    end
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    // State, shift history and output registers with asynchronous reset.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q   <= SEARCH;
            sr0_q     <= '0;
            sr1_q     <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            half_q    <= 1'b0;
            hold_hi_q <= '0;
            hold_lo_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            sr0_q     <= byte0_d[6:0];
            sr1_q     <= byte1_d[6:0];
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            half_q    <= half_d;
            hold_hi_q <= hold_hi_d;
            hold_lo_q <= hold_lo_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign Data_out   = data_q;
    assign valid_out  = valid_q;
    assign active_out = (state_q == SYNC);

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// tb_phy_rx_deserializer
// Directed bench for the two-lane receive deserializer. Bits are driven just
// after each rising edge and outputs are sampled 1 ns after the next one.
module tb_phy_rx_deserializer;

    localparam logic [7:0] COM = 8'hBC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lane0;
    logic        lane1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active_out;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int vpulses  = 0;
    int vcyc     = 0;
    int p0       = 0;
    int c1       = 0;

    phy_rx_deserializer #(
        .COM_BYTE     (8'hBC),
        .COMS_TO_SYNC (4)
    ) dut (
        .clk_32f        (clk),
        .reset          (rst_n),
        .Data_in_1bit_0 (lane0),
        .Data_in_1bit_1 (lane1),
        .Data_out       (data_out),
        .valid_out      (valid_out),
        .active_out     (active_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bit per lane, then sample after the edge and log any valid pulse.
    task automatic step(input logic b0, input logic b1);
        lane0 = b0;
        lane1 = b1;
        @(posedge clk);
        #1;
        cyc++;
        if (valid_out === 1'b1) begin
            vpulses++;
            vcyc = cyc;
        end
    endtask

    task automatic send_pair(input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 7; i >= 0; i--) begin
            step(b0[i], b1[i]);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_pair(w[31:24], w[15:8]);
        send_pair(w[23:16], w[7:0]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
        end
        check("rst_data", data_out, 32'h0);
        check("rst_valid", {31'b0, valid_out}, 32'h0);
        check("rst_active", {31'b0, active_out}, 32'h0);
        rst_n = 1'b1;
    endtask

    // Four COM pairs: active rises exactly on the fourth.
    task automatic sync_up(input string tag);
        p0 = vpulses;
        for (int i = 0; i < 3; i++) begin
            send_pair(COM, COM);
        end
        check({tag, "_active_after3"}, {31'b0, active_out}, 32'h0);
        send_pair(COM, COM);
        check({tag, "_active_after4"}, {31'b0, active_out}, 32'h1);
        check({tag, "_no_valid"}, vpulses - p0, 32'h0);
    endtask

    // Word with mid-word, completion-edge and count checks.
    task automatic rx_word(input string tag, input logic [31:0] w);
        p0 = vpulses;
        send_pair(w[31:24], w[15:8]);
        check({tag, "_no_half_valid"}, vpulses - p0, 32'h0);
        send_pair(w[23:16], w[7:0]);
        check({tag, "_valid_now"}, {31'b0, valid_out}, 32'h1);
        check({tag, "_pulses"}, vpulses - p0, 32'h1);
        check({tag, "_data"}, data_out, w);
    endtask

    task automatic back_to_back(input string tag);
        rx_word({tag, "_w1"}, 32'hFFFF_FFFF);
        c1 = vcyc;
        rx_word({tag, "_w2"}, 32'hEEEE_EEEE);
        check({tag, "_spacing"}, vcyc - c1, 32'd16);
    endtask

    initial begin
        rst_n = 1'b0;
        lane0 = 1'b0;
        lane1 = 1'b0;

        // 1: reset, then four aligned COM pairs.
        do_reset();
        sync_up("t1");
        check("t1_data_held", data_out, 32'h0);

        // 2: two back-to-back words, pulses 16 cycles apart.
        back_to_back("t2");

        // 4: half word then idle; the half must be discarded.
        p0 = vpulses;
        send_pair(8'h00, 8'h00);
        send_pair(COM, COM);
        check("t4_no_valid", vpulses - p0, 32'h0);
        check("t4_data_held", data_out, 32'hEEEE_EEEE);
        check("t4_active", {31'b0, active_out}, 32'h1);
        rx_word("t4_next", 32'h1122_3344);

        // 5: lane error right after a half word; error beats completion.
        p0 = vpulses;
        send_pair(8'h5A, 8'h3C);
        send_pair(8'h12, COM);
        check("t5_active_drop", {31'b0, active_out}, 32'h0);
        check("t5_no_valid", vpulses - p0, 32'h0);
        check("t5_data_held", data_out, 32'h1122_3344);
        sync_up("t5");
        rx_word("t5_word", 32'hAAAA_AAAA);

        // 3: COM stream offset by three bits after reset.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
        end
        sync_up("t3");
        back_to_back("t3");

        // 6: asynchronous reset five bits into a word.
        for (int i = 7; i >= 3; i--) begin
            step(1'(8'h99 >> i), 1'(8'h99 >> i));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_data", data_out, 32'h0);
        check("t6_async_valid", {31'b0, valid_out}, 32'h0);
        check("t6_async_active", {31'b0, active_out}, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
        end
        rst_n = 1'b1;
        p0 = vpulses;
        send_word(32'h9999_9999);
        check("t6_no_valid_unsynced", vpulses - p0, 32'h0);
        check("t6_unsynced_active", {31'b0, active_out}, 32'h0);
        check("t6_unsynced_data", data_out, 32'h0);
        sync_up("t6");
        rx_word("t6_word", 32'h5555_5555);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
